// File: rtl/laser_frame_receiver.sv
// laser_frame_receiver: recovers start/8-data/stop framed bytes (LSB first,
// idle-high line) from an oversampled photodiode input and presents them
// through a valid/ready holding register.
// Optional build macro LASER_RX_PARITY_EN adds an even-parity bit between
// data bit 7 and the stop bit, plus a parity_error output pulse.
module laser_frame_receiver #(
  parameter int OVERSAMPLE = 8,
  parameter int CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       laser_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun,
`ifdef LASER_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef LASER_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Mid-bit point of the start bit, and the full-bit sample point afterwards.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [1:0]       r_sync;
  logic             w_rx_s;
  logic             r_rx_prev;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data_out;
  logic             r_data_valid;
  logic             r_framing_err;
  logic             r_overrun;
  logic             w_fall;
  logic             w_cnt_mid;
  logic             w_cnt_last;
  logic             w_cnt_clr;
  logic             w_sample_bit;
  logic             w_stop_ok;
  logic             w_stop_bad;
`ifdef LASER_RX_PARITY_EN
  logic             r_parity;
  logic             r_parity_err;
  logic             w_sample_par;
  logic             w_par_bad;
`endif

  assign w_rx_s     = r_sync[1];
  assign w_fall     = en && r_rx_prev && !w_rx_s;
  assign w_cnt_mid  = (r_cnt == CNT_MID);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous line, plus previous value for edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], laser_in};
      r_rx_prev <= w_rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic; a low enable forces IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (w_fall) w_state_nxt = S_START;
        S_START:     if (w_cnt_mid) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
`ifdef LASER_RX_PARITY_EN
        S_DATA:      if (w_cnt_last && (r_bit_idx == 3'd7)) w_state_nxt = S_PARITY;
        S_PARITY:    if (w_cnt_last) w_state_nxt = S_STOP;
`else
        S_DATA:      if (w_cnt_last && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
`endif
        S_STOP:      if (w_cnt_last) w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_IDLE;
        S_WAIT_IDLE: if (w_rx_s) w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: counter clear, sample strobes and stop-bit verdicts.
  always_comb begin
    w_cnt_clr    = 1'b0;
    w_sample_bit = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
`ifdef LASER_RX_PARITY_EN
    w_sample_par = 1'b0;
    w_par_bad    = 1'b0;
`endif
    if (!en) begin
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:  w_cnt_clr = 1'b1;
        S_START: if (w_cnt_mid) w_cnt_clr = 1'b1;
        S_DATA: begin
          if (w_cnt_last) begin
            w_cnt_clr    = 1'b1;
            w_sample_bit = 1'b1;
          end
        end
`ifdef LASER_RX_PARITY_EN
        S_PARITY: begin
          if (w_cnt_last) begin
            w_cnt_clr    = 1'b1;
            w_sample_par = 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_cnt_last) begin
            w_cnt_clr = 1'b1;
            if (!w_rx_s) w_stop_bad = 1'b1;
`ifdef LASER_RX_PARITY_EN
            else if (^{r_shift, r_parity}) w_par_bad = 1'b1;
`endif
            else w_stop_ok = 1'b1;
          end
        end
        default: w_cnt_clr = 1'b1;
      endcase
    end
  end

  // Bit-period counter, data bit index and LSB-first shift register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
`ifdef LASER_RX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if (w_cnt_clr) r_cnt <= '0;
      else           r_cnt <= r_cnt + 1'b1;
      if (r_state != S_DATA) r_bit_idx <= 3'd0;
      else if (w_sample_bit) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_sample_bit) r_shift <= {w_rx_s, r_shift[7:1]};
`ifdef LASER_RX_PARITY_EN
      if (w_sample_par) r_parity <= w_rx_s;
`endif
    end
  end

  // Holding register with valid/ready handshake; a load in the consume cycle wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out    <= 8'h00;
      r_data_valid  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef LASER_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_framing_err <= w_stop_bad;
      r_overrun     <= w_stop_ok && r_data_valid && !data_ready;
`ifdef LASER_RX_PARITY_EN
      r_parity_err  <= w_par_bad;
`endif
      if (w_stop_ok && (!r_data_valid || data_ready)) begin
        r_data_out   <= r_shift;
        r_data_valid <= 1'b1;
      end else if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign data_out      = r_data_out;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_err;
  assign overrun       = r_overrun;
  assign busy          = (r_state != S_IDLE);
`ifdef LASER_RX_PARITY_EN
  assign parity_error  = r_parity_err;
`endif

endmodule

// File: tb/tb_laser_frame_receiver.sv
// Testbench for laser_frame_receiver: scoreboard of expected bytes checked on
// every data_valid rise, plus per-scenario tasks with inline checks.
module tb_laser_frame_receiver;
  localparam int OS = 8;
`ifdef LASER_RX_PARITY_EN
  localparam int LAT = 2 + OS / 2 + 10 * OS + 1;
`else
  localparam int LAT = 2 + OS / 2 + 9 * OS + 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       laser_in = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;
`ifdef LASER_RX_PARITY_EN
  logic       parity_error;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic [7:0] sb_q[$];

  laser_frame_receiver #(.OVERSAMPLE(OS), .CNT_W(6)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .en(en),
    .laser_in(laser_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .framing_error(framing_error),
    .overrun(overrun),
`ifdef LASER_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: flag pulse counting and scoreboard comparison on each new byte.
  always @(negedge clock) begin
    logic [7:0] exp_b;
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef LASER_RX_PARITY_EN
    if (parity_error) pe_cnt++;
`endif
    if (data_valid && !prev_valid) begin
      rise_cyc = cyc;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: data_out=%h but no byte expected", data_out);
      end else begin
        exp_b = sb_q.pop_front();
        if (data_out !== exp_b) begin
          n_fail++;
          $display("FAIL sb_byte: data_out=%h expected=%h", data_out, exp_b);
        end
      end
    end
    prev_valid = data_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    laser_in = b;
    repeat (OS) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef LASER_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  task automatic drain();
    data_ready = 1'b1;
    @(posedge clock);
    #1;
    data_ready = 1'b0;
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_valid: data_valid=%b expected=0", data_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks += 5;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got=%h expected=00", data_out); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got=%b expected=0", data_valid); end
    if (framing_error !== 1'b0) begin n_fail++; $display("FAIL rst_fe: got=%b expected=0", framing_error); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got=%b expected=0", overrun); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got=%b expected=0", busy); end
    reset_n = 1'b1;
    en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    int f0, o0, c0;
    f0 = fe_cnt; o0 = ov_cnt;
    rise_cyc = -1;
    sb_q.push_back(8'hC8);
    c0 = cyc;
    send_frame(8'hC8, 1'b1);
    n_checks += 5;
    if (rise_cyc - c0 !== LAT) begin n_fail++; $display("FAIL basic_latency: got=%0d expected=%0d", rise_cyc - c0, LAT); end
    if (data_out !== 8'hC8 || data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_data: got=%h/%b expected=c8/1", data_out, data_valid); end
    if (fe_cnt !== f0 || ov_cnt !== o0) begin n_fail++; $display("FAIL basic_flags: fe=%0d ov=%0d expected=%0d/%0d", fe_cnt, ov_cnt, f0, o0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got=%b expected=0", busy); end
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL basic_pending: got=%0d expected=0", sb_q.size()); end
    drain();
  endtask

  task automatic test_back_to_back();
    int f0, o0;
    f0 = fe_cnt; o0 = ov_cnt;
    sb_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    n_checks += 3;
    if (data_out !== 8'h12 || data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold: got=%h/%b expected=12/1", data_out, data_valid); end
    if (ov_cnt !== o0 + 1) begin n_fail++; $display("FAIL b2b_overrun: pulses=%0d expected=%0d", ov_cnt - o0, 1); end
    if (fe_cnt !== f0) begin n_fail++; $display("FAIL b2b_fe: pulses=%0d expected=0", fe_cnt - f0); end
    drain();
  endtask

  task automatic test_framing();
    int f0, o0;
    f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h77, 1'b0);
    repeat (30) @(posedge clock);
    #1;
    n_checks += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fe_busy_low: got=%b expected=1", busy); end
    if (fe_cnt !== f0 + 1) begin n_fail++; $display("FAIL fe_pulse: pulses=%0d expected=1", fe_cnt - f0); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL fe_valid: got=%b expected=0", data_valid); end
    laser_in = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fe_busy_high: got=%b expected=0", busy); end
    repeat (20) @(posedge clock);
    #1;
    n_checks += 2;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL fe_false_start: busy=%b valid=%b expected=0/0", busy, data_valid); end
    if (fe_cnt !== f0 + 1 || ov_cnt !== o0) begin n_fail++; $display("FAIL fe_flags_after: fe=%0d ov=%0d expected=1/0", fe_cnt - f0, ov_cnt - o0); end
  endtask

  task automatic test_glitch();
    int f0, o0;
    f0 = fe_cnt; o0 = ov_cnt;
    laser_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    laser_in = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start: busy=%b expected=1", busy); end
    repeat (8) @(posedge clock);
    #1;
    n_checks += 2;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_reject: busy=%b valid=%b expected=0/0", busy, data_valid); end
    if (fe_cnt !== f0 || ov_cnt !== o0) begin n_fail++; $display("FAIL glitch_flags: fe=%0d ov=%0d expected=0/0", fe_cnt - f0, ov_cnt - o0); end
    sb_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    n_checks++;
    if (data_out !== 8'h34 || data_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_next: got=%h/%b expected=34/1", data_out, data_valid); end
    drain();
  endtask

  task automatic partial_34();
    logic [7:0] d;
    d = 8'h34;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    laser_in = d[4];
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_abort_en();
    int f0, o0;
    logic [7:0] d;
    d = 8'h34;
    f0 = fe_cnt; o0 = ov_cnt;
    partial_34();
    en = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL en_abort_busy: got=%b expected=0", busy); end
    repeat (5) @(posedge clock);
    #1;
    for (int i = 5; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    en = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    n_checks += 2;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL en_abort_valid: valid=%b busy=%b expected=0/0", data_valid, busy); end
    if (fe_cnt !== f0 || ov_cnt !== o0) begin n_fail++; $display("FAIL en_abort_flags: fe=%0d ov=%0d expected=0/0", fe_cnt - f0, ov_cnt - o0); end
    sb_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    n_checks++;
    if (data_out !== 8'h12 || data_valid !== 1'b1) begin n_fail++; $display("FAIL en_next: got=%h/%b expected=12/1", data_out, data_valid); end
    drain();
  endtask

  task automatic test_abort_reset();
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== 8'h55) begin n_fail++; $display("FAIL rst_pre: got=%h/%b expected=55/1", data_out, data_valid); end
    partial_34();
    #1;
    reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (data_valid !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL rst_async_data: got=%h/%b expected=00/0", data_out, data_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got=%b expected=0", busy); end
    if (framing_error !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rst_async_flags: fe=%b ov=%b expected=0/0", framing_error, overrun); end
    laser_in = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_release: valid=%b busy=%b expected=0/0", data_valid, busy); end
    sb_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    n_checks++;
    if (data_out !== 8'h12 || data_valid !== 1'b1) begin n_fail++; $display("FAIL rst_next: got=%h/%b expected=12/1", data_out, data_valid); end
    drain();
  endtask

`ifdef LASER_RX_PARITY_EN
  task automatic test_parity();
    int p0, f0;
    logic [7:0] d;
    d = 8'h12;
    p0 = pe_cnt; f0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (2) @(posedge clock);
    #1;
    n_checks += 2;
    if (pe_cnt !== p0 + 1 || fe_cnt !== f0) begin n_fail++; $display("FAIL par_bad: pe=%0d fe=%0d expected=1/0", pe_cnt - p0, fe_cnt - f0); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL par_bad_valid: got=%b expected=0", data_valid); end
    sb_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    n_checks++;
    if (data_out !== 8'h12 || data_valid !== 1'b1 || pe_cnt !== p0 + 1) begin n_fail++; $display("FAIL par_good: got=%h/%b pe=%0d expected=12/1/1", data_out, data_valid, pe_cnt - p0); end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_abort_en();
    test_abort_reset();
`ifdef LASER_RX_PARITY_EN
    test_parity();
`endif
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: pending=%0d expected=0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
